sequenciador_instrucoes: RTL and testbench
==========================================

# sequenciador_instrucoes

Instruction sequencer for the simple processor. Fetches 8-bit instructions (opcode[7:4], operand[3:0]) from program memory and steps a fetch/decode/execute FSM. Drives the ULA operation strobe, data-memory rd/we for store-result and load-to-A, relative jumps and halt. Sits between program ROM, the ULA and data RAM, and replaces ad-hoc opcode handling with a cycle-exact sequence.

## Interface
- PC_WIDTH, 8, program counter and program address width.
- DATA_WIDTH, 8, data-memory, ULA result and register A width.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- run  in  1  level; starts/continues execution from IDLE.
- progAddr  out  PC_WIDTH  program memory address.
- progRd  out  1  program read strobe; data valid one cycle later.
- progData  in  8  instruction word.
- ulaOp  out  4  operation code forwarded to the ULA.
- ulaEn  out  1  one-cycle pulse; ULA loads regSaidaULA at that edge.
- regSaidaULA  in  DATA_WIDTH  ULA output register.
- rd  out  1  data-memory read strobe.
- we  out  1  data-memory write strobe.
- memAddr  out  4  data-memory address (= operand).
- dataInMem  out  DATA_WIDTH  write data.
- dataOutMem  in  DATA_WIDTH  read data, valid one cycle after rd.
- regA  out  DATA_WIDTH  register A.
- ledSaidaMem  out  DATA_WIDTH  last loaded value, for LEDs.
- busy  out  1  high whenever state is not IDLE or HALT.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, LOADWB, HALT (plus PAUSE, see Configuration).
- IDLE: all strobes low; run=1 -> FETCH.
- FETCH: progAddr=pc, progRd=1 -> DECODE.
- DECODE: ir <= progData -> EXEC.
- EXEC by ir[7:4]:
  - 0000 NOP: pc <= pc+1.
  - 0001–1011 ALU: ulaOp=ir[7:4], ulaEn=1; pc <= pc+1.
  - 1100 STORE: we=1, memAddr=operand, dataInMem=regSaidaULA; pc <= pc+1.
  - 1101 LOAD: rd=1, memAddr=operand -> LOADWB.
  - 1110 JUMP: pc <= pc + sign-extended operand (−8..+7), modulo 2^PC_WIDTH; offset 0 is a one-instruction self-loop.
  - 1111 HALT: -> HALT, pc unchanged.
- LOADWB: regA <= dataOutMem, ledSaidaMem <= dataOutMem; pc <= pc+1.
- After EXEC (non-LOAD/HALT) or LOADWB: -> FETCH if run=1, else IDLE (run is sampled only at instruction boundaries; an instruction in flight always completes).
- pc+1 wraps from 2^PC_WIDTH−1 to 0.
- HALT exits only via reset; run ignored.
- rd, we, ulaEn, progRd are never high together; each is high for exactly one cycle per instruction that uses it.

## Timing
- Reset values: pc=0, ir=0, state IDLE, progAddr=0, progRd=0, ulaOp=0, ulaEn=0, rd=0, we=0, memAddr=0, dataInMem=0, regA=0, ledSaidaMem=0, busy=0, halted=0.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Latency: NOP/ALU/STORE/JUMP take 3 cycles; LOAD takes 4.
- A STORE immediately after an ALU op writes the new result, since the ULA registers it on the ulaEn edge.
- Reset asserted in any state: reset values at the next edge. Any strobe high in that cycle still reaches memory; nothing is issued afterwards.

## Configuration
- SEQ_SINGLE_STEP_EN defined: adds input step (1 bit) and state PAUSE. Every instruction boundary goes to PAUSE instead of FETCH. A one-cycle step pulse moves to FETCH. run=0 in PAUSE moves to IDLE. busy is low in PAUSE.
- Not defined: no step port, no PAUSE state; behaviour exactly as above.

## Structure
- Package seq_pkg: opcode constants (OP_NOP, OP_STORE=4'b1100, OP_LOAD=4'b1101, OP_JUMP, OP_HALT), ALU opcode range limits, state enum.
- Sub-module seq_decoder (combinational): ir[7:4] -> isAlu/isStore/isLoad/isJump/isHalt. FSM and datapath registers stay in the top module.

## Test plan
- ROM {0x13, 0xC5, 0xD5, 0xF0}, ULA result 0x2A, run=1 -> ulaEn at cycle 3, we with memAddr=5 and dataInMem=0x2A at cycle 6, regA=ledSaidaMem=0x2A after LOADWB, halted=1 with pc=3.
- pc=0xFE, JUMP operand 0x3 -> pc=0x01 (wrap). pc=0x02, JUMP operand 0xC (−4) -> pc=0xFE.
- run dropped during EXEC of an ALU op -> ulaEn still pulses, pc increments, state IDLE with busy=0; run re-raised -> FETCH at the new pc.
- reset pulsed during LOADWB -> regA=0, pc=0, IDLE next cycle; no further rd/we.
- HALT reached, then run toggled -> halted stays 1, no progRd, until reset.
- With SEQ_SINGLE_STEP_EN: three NOPs, step pulsed twice -> pc=2 and state PAUSE; no fetch without a step pulse.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcode constants, state encoding and opcode helpers for the instruction sequencer.
// SEQ_SINGLE_STEP_EN adds the PAUSE state used by single-step execution.
package seq_pkg;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_ALU_MIN = 4'b0001;
    localparam logic [3:0] OP_ALU_MAX = 4'b1011;
    localparam logic [3:0] OP_STORE   = 4'b1100;
    localparam logic [3:0] OP_LOAD    = 4'b1101;
    localparam logic [3:0] OP_JUMP    = 4'b1110;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_LOADWB = 3'd4,
`ifdef SEQ_SINGLE_STEP_EN
        ST_HALT   = 3'd5,
        ST_PAUSE  = 3'd6
`else
        ST_HALT   = 3'd5
`endif
    } seq_state_e;

    // Where execution resumes at an instruction boundary while run is held high.
`ifdef SEQ_SINGLE_STEP_EN
    localparam seq_state_e ST_RESUME = ST_PAUSE;
`else
    localparam seq_state_e ST_RESUME = ST_FETCH;
`endif

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ALU_MIN) && (op <= OP_ALU_MAX);
    endfunction

endpackage

// File: rtl/seq_decoder.sv
// Combinational opcode classifier: maps ir[7:4] onto one-hot instruction class flags.
module seq_decoder
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_nop,
    output logic       is_alu,
    output logic       is_store,
    output logic       is_load,
    output logic       is_jump,
    output logic       is_halt
);

    // Classify the opcode; exactly one flag is high for any 4-bit value
    always_comb begin
        is_nop   = (opcode == OP_NOP);
        is_alu   = is_alu_op(opcode);
        is_store = (opcode == OP_STORE);
        is_load  = (opcode == OP_LOAD);
        is_jump  = (opcode == OP_JUMP);
        is_halt  = (opcode == OP_HALT);
    end

endmodule

// File: rtl/sequenciador_instrucoes.sv
// Fetch/decode/execute sequencer driving program ROM, ULA strobes and data RAM.
// Optional single-step mode is enabled by defining SEQ_SINGLE_STEP_EN.
module sequenciador_instrucoes
    import seq_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [PC_WIDTH-1:0]   progAddr,
    output logic                  progRd,
    input  logic [7:0]            progData,
    output logic [3:0]            ulaOp,
    output logic                  ulaEn,
    input  logic [DATA_WIDTH-1:0] regSaidaULA,
    output logic                  rd,
    output logic                  we,
    output logic [3:0]            memAddr,
    output logic [DATA_WIDTH-1:0] dataInMem,
    input  logic [DATA_WIDTH-1:0] dataOutMem,
    output logic [DATA_WIDTH-1:0] regA,
    output logic [DATA_WIDTH-1:0] ledSaidaMem,
    output logic                  busy,
    output logic                  halted
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    seq_state_e            state_r;
    seq_state_e            state_s;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [7:0]            ir_r;
    logic [3:0]            ula_op_r;
    logic [3:0]            mem_addr_r;
    logic [DATA_WIDTH-1:0] data_in_mem_r;
    logic [DATA_WIDTH-1:0] reg_a_r;
    logic [DATA_WIDTH-1:0] led_r;
    logic [PC_WIDTH-1:0]   jump_offset_s;
    logic                  exec_s;
    logic                  is_nop_s;
    logic                  is_alu_s;
    logic                  is_store_s;
    logic                  is_load_s;
    logic                  is_jump_s;
    logic                  is_halt_s;

    seq_decoder u_decoder (
        .opcode   (ir_r[7:4]),
        .is_nop   (is_nop_s),
        .is_alu   (is_alu_s),
        .is_store (is_store_s),
        .is_load  (is_load_s),
        .is_jump  (is_jump_s),
        .is_halt  (is_halt_s)
    );

    assign jump_offset_s = {{(PC_WIDTH-4){ir_r[3]}}, ir_r[3:0]};
    assign exec_s        = (state_r == ST_EXEC);

    // Next-state selection; run is only consulted at instruction boundaries
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_RESUME;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH:  state_s = ST_DECODE;
            ST_DECODE: state_s = ST_EXEC;
            ST_EXEC: begin
                if (is_halt_s) begin
                    state_s = ST_HALT;
                end else if (is_load_s) begin
                    state_s = ST_LOADWB;
                end else if (run) begin
                    state_s = ST_RESUME;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOADWB: begin
                if (run) begin
                    state_s = ST_RESUME;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HALT:   state_s = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (!run) begin
                    state_s = ST_IDLE;
                end else if (step) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
`endif
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register and datapath updates
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= {PC_WIDTH{1'b0}};
            ir_r          <= 8'h00;
            ula_op_r      <= 4'b0000;
            mem_addr_r    <= 4'b0000;
            data_in_mem_r <= {DATA_WIDTH{1'b0}};
            reg_a_r       <= {DATA_WIDTH{1'b0}};
            led_r         <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_DECODE: begin
                    ir_r     <= progData;
                    ula_op_r <= is_alu_op(progData[7:4]) ? progData[7:4] : 4'b0000;
                    // Operand and store data are latched a cycle early so EXEC outputs stay registered;
                    // an ALU result from the previous instruction is already in regSaidaULA here.
                    if ((progData[7:4] == OP_STORE) || (progData[7:4] == OP_LOAD)) begin
                        mem_addr_r <= progData[3:0];
                    end else begin
                        mem_addr_r <= mem_addr_r;
                    end
                    if (progData[7:4] == OP_STORE) begin
                        data_in_mem_r <= regSaidaULA;
                    end else begin
                        data_in_mem_r <= data_in_mem_r;
                    end
                end
                ST_EXEC: begin
                    if (is_jump_s) begin
                        pc_r <= pc_r + jump_offset_s;
                    end else if (is_nop_s || is_alu_s || is_store_s) begin
                        pc_r <= pc_r + PC_ONE;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_LOADWB: begin
                    reg_a_r <= dataOutMem;
                    led_r   <= dataOutMem;
                    pc_r    <= pc_r + PC_ONE;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign progAddr    = pc_r;
    assign progRd      = (state_r == ST_FETCH);
    assign ulaOp       = ula_op_r;
    assign ulaEn       = exec_s && is_alu_s;
    assign we          = exec_s && is_store_s;
    assign rd          = exec_s && is_load_s;
    assign memAddr     = mem_addr_r;
    assign dataInMem   = data_in_mem_r;
    assign regA        = reg_a_r;
    assign ledSaidaMem = led_r;
    assign halted      = (state_r == ST_HALT);
`ifdef SEQ_SINGLE_STEP_EN
    assign busy        = (state_r != ST_IDLE) && (state_r != ST_HALT) && (state_r != ST_PAUSE);
`else
    assign busy        = (state_r != ST_IDLE) && (state_r != ST_HALT);
`endif

endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Directed self-checking bench for sequenciador_instrucoes with ROM, ULA and RAM models.
module tb_sequenciador_instrucoes;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step;
`endif
    logic [7:0] progAddr;
    logic       progRd;
    logic [7:0] progData = 8'h00;
    logic [3:0] ulaOp;
    logic       ulaEn;
    logic [7:0] regSaidaULA = 8'h00;
    logic       rd;
    logic       we;
    logic [3:0] memAddr;
    logic [7:0] dataInMem;
    logic [7:0] dataOutMem = 8'h00;
    logic [7:0] regA;
    logic [7:0] ledSaidaMem;
    logic       busy;
    logic       halted;

    logic [7:0] rom [256];
    logic [7:0] ram [16];
    int checks = 0;
    int failures = 0;
    int overlaps = 0;

    sequenciador_instrucoes #(.PC_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .progAddr    (progAddr),
        .progRd      (progRd),
        .progData    (progData),
        .ulaOp       (ulaOp),
        .ulaEn       (ulaEn),
        .regSaidaULA (regSaidaULA),
        .rd          (rd),
        .we          (we),
        .memAddr     (memAddr),
        .dataInMem   (dataInMem),
        .dataOutMem  (dataOutMem),
        .regA        (regA),
        .ledSaidaMem (ledSaidaMem),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    // ROM, ULA and RAM models with one-cycle registered responses
    always @(posedge clock) begin
        if (progRd) progData <= rom[progAddr];
        if (ulaEn) regSaidaULA <= 8'h2A;
        if (we) ram[memAddr] <= dataInMem;
        if (rd) dataOutMem <= ram[memAddr];
    end

    // Strobe exclusivity monitor
    always @(negedge clock) begin
        if (((rd === 1'b1) + (we === 1'b1) + (ulaEn === 1'b1) + (progRd === 1'b1)) > 1)
            overlaps++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        clear_rom();
        tick();
        tick();
        check("rst_progAddr", progAddr, 8'h00);
        check("rst_strobes", {progRd, ulaEn, rd, we}, 4'h0);
        check("rst_ulaOp", ulaOp, 4'h0);
        check("rst_memAddr", memAddr, 4'h0);
        check("rst_dataInMem", dataInMem, 8'h00);
        check("rst_regA_led", {regA, ledSaidaMem}, 16'h0000);
        check("rst_busy_halted", {busy, halted}, 2'b00);
        reset = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
        // Three NOPs, two step pulses
        tick();
        run = 1'b1;
        tick();
        check("ss_pause_busy", busy, 1'b0);
        tick();
        tick();
        check("ss_no_fetch", progRd, 1'b0);
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick();
            check("ss_fetch", progRd, 1'b1);
            step = 1'b0;
            tick();
            tick();
            tick();
            check("ss_back_pause", {busy, progRd}, 2'b00);
        end
        check("ss_pc2", progAddr, 8'h02);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ss_hold", {progRd, progAddr}, 9'h002);
        end
`else
        // Main program: ALU, STORE 5, LOAD 5, HALT
        rom[0] = 8'h13; rom[1] = 8'hC5; rom[2] = 8'hD5; rom[3] = 8'hF0;
        tick();
        check("idle_run0", {busy, progRd}, 2'b00);
        run = 1'b1;
        tick();
        check("c1_fetch", {progRd, progAddr}, 9'h100);
        check("c1_busy", busy, 1'b1);
        tick();
        tick();
        check("c3_ulaEn", {ulaEn, ulaOp}, 5'h11);
        tick();
        tick();
        tick();
        check("c6_we", {we, memAddr, dataInMem}, 13'h1_5_2A);
        tick();
        tick();
        tick();
        check("c9_rd", {rd, memAddr}, 5'h15);
        tick();
        tick();
        check("c11_regA_led", {regA, ledSaidaMem}, 16'h2A2A);
        check("c11_fetch_pc3", {progRd, progAddr}, 9'h103);
        tick();
        tick();
        tick();
        check("c14_halted", {halted, busy}, 2'b10);
        check("c14_pc3", progAddr, 8'h03);

        // HALT ignores run
        run = 1'b0;
        tick();
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("halt_hold", {halted, progRd}, 2'b10);
        end

        // pc+1 wrap: jump -1 to 0xFF, NOP there wraps to 0x00
        do_reset();
        clear_rom();
        rom[8'h00] = 8'hEF;
        rom[8'hFF] = 8'h00;
        run = 1'b1;
        tick();
        check("wrap_f0", progAddr, 8'h00);
        tick(); tick(); tick();
        check("wrap_fFF", {progRd, progAddr}, 9'h1FF);
        tick(); tick(); tick();
        check("wrap_f00", {progRd, progAddr}, 9'h100);

        // Relative jumps with wrap in both directions
        do_reset();
        clear_rom();
        rom[8'h00] = 8'hEE;
        rom[8'hFE] = 8'hE3;
        rom[8'h01] = 8'hE1;
        rom[8'h02] = 8'hEC;
        run = 1'b1;
        tick();
        tick(); tick(); tick();
        check("jmp_to_FE", {progRd, progAddr}, 9'h1FE);
        tick(); tick(); tick();
        check("jmp_FE_p3", {progRd, progAddr}, 9'h101);
        tick(); tick(); tick();
        check("jmp_01_p1", {progRd, progAddr}, 9'h102);
        tick(); tick(); tick();
        check("jmp_02_m4", {progRd, progAddr}, 9'h1FE);

        // run dropped during EXEC of an ALU op
        do_reset();
        clear_rom();
        rom[0] = 8'h13;
        rom[1] = 8'h13;
        run = 1'b1;
        tick();
        tick();
        tick();
        check("drop_ulaEn", ulaEn, 1'b1);
        run = 1'b0;
        tick();
        check("drop_idle", {busy, progRd, progAddr}, 10'h001);
        tick();
        check("drop_stay", {busy, progRd}, 2'b00);
        run = 1'b1;
        tick();
        check("drop_resume", {progRd, progAddr}, 9'h101);

        // reset during LOADWB
        do_reset();
        clear_rom();
        rom[0] = 8'hD5;
        rom[1] = 8'hD5;
        rom[2] = 8'hF0;
        run = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check("lw_first_regA", regA, 8'h2A);
        tick(); tick(); tick();
        check("lw_in_loadwb", {busy, rd, we}, 3'b100);
        reset = 1'b1;
        run = 1'b0;
        tick();
        check("lw_reset", {regA, progAddr, busy}, 17'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("lw_no_mem", {rd, we, progRd}, 3'b000);
        end
`endif

        check("strobe_exclusive", overlaps, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
